// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared opcode map, control bundle layout and micro-op sequencer states
// for the ID/EX decode pipeline.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ALU_LAST = 5'b01100;
  localparam logic [4:0] OP_LD       = 5'b01101;
  localparam logic [4:0] OP_ST       = 5'b01110;
  localparam logic [4:0] OP_ALUA0    = 5'b01111;
  localparam logic [4:0] OP_ALUA1    = 5'b10000;
  localparam logic [4:0] OP_B        = 5'b10001;
  localparam logic [4:0] OP_BEQ      = 5'b10010;
  localparam logic [4:0] OP_JMP      = 5'b10011;
  localparam logic [4:0] OP_FUN      = 5'b10100;
  localparam logic [4:0] OP_RET      = 5'b10101;

  typedef struct packed {
    logic       Reg1Sel;
    logic       wEn;
    logic       ALU_A_SEL;
    logic       ALU_B_SEL;
    logic       B;
    logic       BEQ;
    logic       JMP;
    logic       memIn_sel;
    logic       memwr;
    logic       wbdata_sel;
    logic       wbreg_sel;
    logic       SPwe;
    logic       is_load;
    logic [1:0] Reg0Sel;
    logic [1:0] imm_sel;
  } ctrl_t;

  localparam int CTRLW = $bits(ctrl_t);

  typedef enum logic {RUN, UOP2} uop_state_e;

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// IF/ID -> ID/EX handshake bundle; master is the pipeline around the decoder,
// slave is the decoder itself.
interface ctrl_decode_pipe_if
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int RW  = 3
);
  logic             id_valid;
  logic [OPW-1:0]   id_opcode;
  logic [RW-1:0]    id_rs0;
  logic [RW-1:0]    id_rs1;
  logic [RW-1:0]    id_rd;
  logic             id_stall;
  logic             ex_ready;
  logic             ex_flush;
  logic             ex_valid;
  logic [CTRLW-1:0] ex_ctrl;
  logic [RW-1:0]    ex_rd;
  logic             illegal;

  modport master (
    output id_valid, id_opcode, id_rs0, id_rs1, id_rd, ex_ready, ex_flush,
    input  id_stall, ex_valid, ex_ctrl, ex_rd, illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_rs0, id_rs1, id_rd, ex_ready, ex_flush,
    output id_stall, ex_valid, ex_ctrl, ex_rd, illegal
  );
endinterface

// File: rtl/ctrl_decode_pipe_lut.sv
// Pure combinational opcode -> control bundle table. `second` selects the
// second micro-op bundle of the FUN/RET sequences.
module ctrl_decode_lut
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  input  logic           second,
  output ctrl_t          ctrl,
  output logic           illegal
);
  logic [4:0] op5;
  logic       hi_bad;

  always_comb begin
    op5     = opcode[4:0];
    hi_bad  = (opcode >> 5) != '0;
    ctrl    = '0;
    illegal = 1'b0;
    if (hi_bad) begin
      illegal = 1'b1;
    end else if (op5 <= OP_ALU_LAST) begin
      ctrl.wEn = 1'b1;
    end else begin
      unique case (op5)
        OP_LD:    begin ctrl.wEn = 1'b1; ctrl.is_load = 1'b1; ctrl.ALU_B_SEL = 1'b1; end
        OP_ST:    begin ctrl.memwr = 1'b1; ctrl.ALU_B_SEL = 1'b1; end
        OP_ALUA0,
        OP_ALUA1: begin ctrl.ALU_A_SEL = 1'b1; ctrl.wEn = 1'b1; end
        OP_B:     ctrl.B   = 1'b1;
        OP_BEQ:   ctrl.BEQ = 1'b1;
        OP_JMP:   ctrl.JMP = 1'b1;
        // FUN: push return PC, then jump
        OP_FUN: begin
          if (second) ctrl.JMP = 1'b1;
          else begin ctrl.memwr = 1'b1; ctrl.SPwe = 1'b1; ctrl.memIn_sel = 1'b1; end
        end
        // RET: pop into write-back, then jump to the popped address
        OP_RET: begin
          ctrl.wbdata_sel = 1'b1;
          if (second) ctrl.JMP = 1'b1;
          else        ctrl.SPwe = 1'b1;
        end
        default:  illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// Pipelined opcode decoder: ID/EX control register with load-use interlock,
// branch flush, back-pressure and a two-micro-op FUN/RET sequencer.
module ctrl_decode_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int RW     = 3,
  parameter bit ZERO_R = 1'b1
) (
  input logic               clk,
  input logic               rst,
  ctrl_decode_pipe_if.slave bus
);
  uop_state_e    state_q, state_d;
  ctrl_t         lut_ctrl;
  logic          lut_illegal;
  logic          is_seq, hazard;
  logic          hold, nxt_vld, nxt_ill, stall;

  ctrl_t         ex_ctrl_p1;
  logic          ex_vld_p1, illegal_p1;
  logic [RW-1:0] ex_rd_p1;

  function automatic logic reg_hit(input logic [RW-1:0] src, input logic [RW-1:0] dst);
    return (src == dst) && !(ZERO_R && (src == '0));
  endfunction

  ctrl_decode_lut #(.OPW(OPW)) u_lut (
    .opcode (bus.id_opcode),
    .second (state_q == UOP2),
    .ctrl   (lut_ctrl),
    .illegal(lut_illegal)
  );

  assign is_seq = (bus.id_opcode == OPW'(OP_FUN)) || (bus.id_opcode == OPW'(OP_RET));

  // Only the first micro-op is interlocked; rs1 is unused when B comes from the immediate
  assign hazard = (state_q == RUN) && bus.id_valid && !lut_illegal
                  && ex_vld_p1 && ex_ctrl_p1.is_load
                  && (reg_hit(bus.id_rs0, ex_rd_p1)
                      || (!lut_ctrl.ALU_B_SEL && reg_hit(bus.id_rs1, ex_rd_p1)));

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    hold    = 1'b0;
    nxt_vld = 1'b0;
    nxt_ill = 1'b0;
    if (!rst) begin
      if (bus.ex_flush) begin
        state_d = RUN;
      end else if (!bus.ex_ready) begin
        stall = 1'b1;
        hold  = 1'b1;
      end else if (state_q == UOP2) begin
        state_d = RUN;
        nxt_vld = 1'b1;
      end else if (hazard) begin
        stall = 1'b1;
      end else begin
        nxt_vld = bus.id_valid && !lut_illegal;
        nxt_ill = bus.id_valid && lut_illegal;
        if (bus.id_valid && is_seq) begin
          stall   = 1'b1;
          state_d = UOP2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // ID/EX stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_vld_p1  <= 1'b0;
      illegal_p1 <= 1'b0;
      ex_ctrl_p1 <= '0;
      ex_rd_p1   <= '0;
    end else begin
      illegal_p1 <= nxt_ill;
      if (!hold) begin
        ex_vld_p1  <= nxt_vld;
        ex_ctrl_p1 <= nxt_vld ? lut_ctrl : '0;
        ex_rd_p1   <= nxt_vld ? bus.id_rd : '0;
      end
    end
  end

  assign bus.id_stall = stall;
  assign bus.ex_valid = ex_vld_p1;
  assign bus.ex_ctrl  = ex_ctrl_p1;
  assign bus.ex_rd    = ex_rd_p1;
  assign bus.illegal  = illegal_p1;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Cycle table for ctrl_decode_pipe: each row drives one cycle, checks id_stall
// and queues the ID/EX contents expected after the following clock edge.
module tb_ctrl_decode_pipe;
  import cpu_ctrl_pkg::*;

  localparam int OPW = 5;
  localparam int RW  = 3;

  // ctrl_t bit positions, MSB first: Reg1Sel,wEn,ALU_A_SEL,ALU_B_SEL,B,BEQ,JMP,memIn_sel,memwr,wbdata_sel,wbreg_sel,SPwe,is_load,Reg0Sel[2],imm_sel[2]
  localparam logic [16:0] WEN = 17'h08000, ASEL = 17'h04000, BSEL = 17'h02000;
  localparam logic [16:0] BR  = 17'h01000, BEQ  = 17'h00800, JMP  = 17'h00400;
  localparam logic [16:0] MIN = 17'h00200, MWR  = 17'h00100, WBD  = 17'h00080;
  localparam logic [16:0] SPW = 17'h00020, LDB  = 17'h00010;
  localparam logic [16:0] C0 = 17'h0, C_ALU = WEN, C_LD = WEN | LDB | BSEL, C_ST = MWR | BSEL;
  localparam logic [16:0] C_ALUA = ASEL | WEN, C_PUSH = MWR | SPW | MIN, C_POP = SPW | WBD;
  localparam logic [16:0] C_JWB = JMP | WBD;

  typedef struct {
    logic        r, vld;
    logic [4:0]  op;
    logic [2:0]  rs0, rs1, rd;
    logic        rdy, fl, stall, evld;
    logic [16:0] ctrl;
    logic [2:0]  erd;
    logic        ill;
  } vec_t;

  typedef struct {
    int          idx;
    logic        evld;
    logic [16:0] ctrl;
    logic [2:0]  erd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t vecs[$];
  exp_t sb[$];
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe_if #(.OPW(OPW), .RW(RW)) bus ();

  ctrl_decode_pipe #(.OPW(OPW), .RW(RW), .ZERO_R(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic vec_t v(input logic r, input logic vld, input logic [4:0] op,
                             input logic [2:0] rs0, input logic [2:0] rs1, input logic [2:0] rd,
                             input logic rdy, input logic fl, input logic stall, input logic evld,
                             input logic [16:0] c, input logic [2:0] erd, input logic ill);
    vec_t x;
    x.r = r; x.vld = vld; x.op = op; x.rs0 = rs0; x.rs1 = rs1; x.rd = rd;
    x.rdy = rdy; x.fl = fl; x.stall = stall; x.evld = evld; x.ctrl = c; x.erd = erd; x.ill = ill;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_valid", e.idx, 32'(bus.ex_valid), 32'(e.evld));
      chk("ex_ctrl",  e.idx, 32'(bus.ex_ctrl),  32'(e.ctrl));
      chk("ex_rd",    e.idx, 32'(bus.ex_rd),    32'(e.erd));
      chk("illegal",  e.idx, 32'(bus.illegal),  32'(e.ill));
    end
  end

  initial begin
    exp_t e;
    //                 r  vld op        rs0 rs1 rd  rdy fl  stall evld ctrl    erd ill
    // reset with a JMP waiting in IF/ID
    vecs.push_back(v(1, 1, 5'b10011, 0, 0, 1, 1, 0, 0, 0, C0,     0, 0));
    vecs.push_back(v(1, 1, 5'b10011, 0, 0, 1, 1, 0, 0, 0, C0,     0, 0));
    // load-use on rs0, then same with rd=0
    vecs.push_back(v(0, 1, 5'b01101, 1, 2, 3, 1, 0, 0, 1, C_LD,   3, 0));
    vecs.push_back(v(0, 1, 5'b00000, 3, 4, 5, 1, 0, 1, 0, C0,     0, 0));
    vecs.push_back(v(0, 1, 5'b00000, 3, 4, 5, 1, 0, 0, 1, C_ALU,  5, 0));
    vecs.push_back(v(0, 1, 5'b01101, 1, 2, 0, 1, 0, 0, 1, C_LD,   0, 0));
    vecs.push_back(v(0, 1, 5'b00000, 0, 0, 6, 1, 0, 0, 1, C_ALU,  6, 0));
    // rs1 ignored under ALU_B_SEL, checked otherwise
    vecs.push_back(v(0, 1, 5'b01101, 1, 2, 4, 1, 0, 0, 1, C_LD,   4, 0));
    vecs.push_back(v(0, 1, 5'b01110, 1, 4, 7, 1, 0, 0, 1, C_ST,   7, 0));
    vecs.push_back(v(0, 1, 5'b01101, 1, 2, 5, 1, 0, 0, 1, C_LD,   5, 0));
    vecs.push_back(v(0, 1, 5'b01111, 1, 5, 2, 1, 0, 1, 0, C0,     0, 0));
    vecs.push_back(v(0, 1, 5'b01111, 1, 5, 2, 1, 0, 0, 1, C_ALUA, 2, 0));
    // FUN sequence, then FUN aborted by flush in its second cycle
    vecs.push_back(v(0, 1, 5'b10100, 1, 2, 1, 1, 0, 1, 1, C_PUSH, 1, 0));
    vecs.push_back(v(0, 1, 5'b10100, 1, 2, 1, 1, 0, 0, 1, JMP,    1, 0));
    vecs.push_back(v(0, 1, 5'b00001, 1, 2, 2, 1, 0, 0, 1, C_ALU,  2, 0));
    vecs.push_back(v(0, 1, 5'b10100, 1, 2, 3, 1, 0, 1, 1, C_PUSH, 3, 0));
    vecs.push_back(v(0, 1, 5'b10100, 1, 2, 3, 1, 1, 0, 0, C0,     0, 0));
    vecs.push_back(v(0, 1, 5'b00010, 1, 2, 4, 1, 0, 0, 1, C_ALU,  4, 0));
    // RET sequence
    vecs.push_back(v(0, 1, 5'b10101, 1, 2, 2, 1, 0, 1, 1, C_POP,  2, 0));
    vecs.push_back(v(0, 1, 5'b10101, 1, 2, 2, 1, 0, 0, 1, C_JWB,  2, 0));
    // back-pressure for 3 cycles, then BEQ issues
    vecs.push_back(v(0, 1, 5'b10001, 1, 2, 5, 1, 0, 0, 1, BR,     5, 0));
    vecs.push_back(v(0, 1, 5'b10010, 1, 2, 6, 0, 0, 1, 1, BR,     5, 0));
    vecs.push_back(v(0, 1, 5'b10010, 1, 2, 6, 0, 0, 1, 1, BR,     5, 0));
    vecs.push_back(v(0, 1, 5'b10010, 1, 2, 6, 0, 0, 1, 1, BR,     5, 0));
    vecs.push_back(v(0, 1, 5'b10010, 1, 2, 6, 1, 0, 0, 1, BEQ,    6, 0));
    // second micro-op waits out back-pressure
    vecs.push_back(v(0, 1, 5'b10101, 1, 2, 7, 1, 0, 1, 1, C_POP,  7, 0));
    vecs.push_back(v(0, 1, 5'b10101, 1, 2, 7, 0, 0, 1, 1, C_POP,  7, 0));
    vecs.push_back(v(0, 1, 5'b10101, 1, 2, 7, 1, 0, 0, 1, C_JWB,  7, 0));
    // illegal opcode: one pulse, bubble, no stall
    vecs.push_back(v(0, 1, 5'b11010, 1, 2, 1, 1, 0, 0, 0, C0,     0, 1));
    vecs.push_back(v(0, 1, 5'b00011, 1, 2, 3, 1, 0, 0, 1, C_ALU,  3, 0));
    // flush beats not-ready and a pending hazard
    vecs.push_back(v(0, 1, 5'b01101, 1, 2, 6, 1, 0, 0, 1, C_LD,   6, 0));
    vecs.push_back(v(0, 1, 5'b00000, 6, 1, 2, 0, 1, 0, 0, C0,     0, 0));
    vecs.push_back(v(0, 1, 5'b00000, 6, 1, 2, 1, 0, 0, 1, C_ALU,  2, 0));
    vecs.push_back(v(0, 0, 5'b00000, 1, 2, 3, 1, 0, 0, 0, C0,     0, 0));
    // load-use hazard delays the whole FUN sequence
    vecs.push_back(v(0, 1, 5'b01101, 1, 2, 5, 1, 0, 0, 1, C_LD,   5, 0));
    vecs.push_back(v(0, 1, 5'b10100, 5, 2, 1, 1, 0, 1, 0, C0,     0, 0));
    vecs.push_back(v(0, 1, 5'b10100, 5, 2, 1, 1, 0, 1, 1, C_PUSH, 1, 0));
    vecs.push_back(v(0, 1, 5'b10100, 5, 2, 1, 1, 0, 0, 1, JMP,    1, 0));
    // reset in the middle of RET leaves no second micro-op behind
    vecs.push_back(v(0, 1, 5'b10101, 1, 2, 4, 1, 0, 1, 1, C_POP,  4, 0));
    vecs.push_back(v(1, 1, 5'b10101, 1, 2, 4, 1, 0, 0, 0, C0,     0, 0));
    vecs.push_back(v(0, 1, 5'b00100, 1, 2, 3, 1, 0, 0, 1, C_ALU,  3, 0));
    // decode-table boundaries
    vecs.push_back(v(0, 1, 5'b01100, 1, 2, 2, 1, 0, 0, 1, C_ALU,  2, 0));
    vecs.push_back(v(0, 1, 5'b10110, 1, 2, 2, 1, 0, 0, 0, C0,     0, 1));
    vecs.push_back(v(0, 1, 5'b10000, 1, 2, 5, 1, 0, 0, 1, C_ALUA, 5, 0));
    vecs.push_back(v(0, 1, 5'b10011, 1, 2, 1, 1, 0, 0, 1, JMP,    1, 0));
    vecs.push_back(v(0, 1, 5'b11111, 1, 2, 1, 1, 0, 0, 0, C0,     0, 1));
    vecs.push_back(v(0, 0, 5'b00000, 1, 2, 1, 1, 0, 0, 0, C0,     0, 0));

    bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_rs0 = '0; bus.id_rs1 = '0;
    bus.id_rd = '0; bus.ex_ready = 1'b1; bus.ex_flush = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      rst           = vecs[i].r;
      bus.id_valid  = vecs[i].vld;
      bus.id_opcode = vecs[i].op;
      bus.id_rs0    = vecs[i].rs0;
      bus.id_rs1    = vecs[i].rs1;
      bus.id_rd     = vecs[i].rd;
      bus.ex_ready  = vecs[i].rdy;
      bus.ex_flush  = vecs[i].fl;
      #1;
      chk("id_stall", i, 32'(bus.id_stall), 32'(vecs[i].stall));
      e.idx = i; e.evld = vecs[i].evld; e.ctrl = vecs[i].ctrl; e.erd = vecs[i].erd; e.ill = vecs[i].ill;
      sb.push_back(e);
      @(negedge clk);
    end
    @(negedge clk);
    chk("scoreboard_drain", vecs.size(), 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
